// File: rtl/kernel_st_arb_pkg.sv
// kernel_st_arb_pkg: shared types, constants and round-robin helper for stream arbiters
package kernel_st_arb_pkg;

  typedef enum logic {IDLE, LOCKED} arb_state_e;

  localparam int DROP_W = 16;
  localparam int MAX_IN = 8;

  // First set bit of req at or after rr, wrapping modulo n; returns rr when req is empty.
  function automatic int rr_winner(input logic [MAX_IN-1:0] req, input int rr, input int n);
    int w;
    w = rr;
    for (int k = MAX_IN - 1; k >= 0; k--)
      if (k < n && req[(rr + k) % n]) w = (rr + k) % n;
    return w;
  endfunction

endpackage

// File: rtl/kernel_rr_arbiter.sv
// kernel_rr_arbiter: combinational round-robin pick of the first request at or after rr
module kernel_rr_arbiter
  import kernel_st_arb_pkg::*;
#(
  parameter int NUM_IN = 4,
  parameter int CH_W   = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [CH_W-1:0]   rr,
  output logic [CH_W-1:0]   gnt_idx,
  output logic              any_req
);

  assign any_req = |req;
  assign gnt_idx = CH_W'(rr_winner(MAX_IN'(req), int'(rr), NUM_IN));

endmodule

// File: rtl/kernel_st_packet_arbiter.sv
// kernel_st_packet_arbiter: packet-locked round-robin mux of NUM_IN Avalon-ST sources
module kernel_st_packet_arbiter
  import kernel_st_arb_pkg::*;
#(
  parameter int NUM_IN  = 4,
  parameter int DATA_W  = 32,
  parameter int EMPTY_W = 2,
  parameter int CH_W    = $clog2(NUM_IN)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_IN-1:0]         in_valid,
  output logic [NUM_IN-1:0]         in_ready,
  input  logic [NUM_IN*DATA_W-1:0]  in_data,
  input  logic [NUM_IN-1:0]         in_startofpacket,
  input  logic [NUM_IN-1:0]         in_endofpacket,
  input  logic [NUM_IN*EMPTY_W-1:0] in_empty,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_startofpacket,
  output logic                      out_endofpacket,
  output logic [EMPTY_W-1:0]        out_empty,
  output logic [CH_W-1:0]           out_channel,
  output logic                      busy,
  output logic [DROP_W-1:0]         drop_count
);

  localparam int CNT_W = $clog2(NUM_IN + 1);

  arb_state_e          state_q, state_d;
  logic [CH_W-1:0]     g_q, g_d, rr_q, rr_d, win;
  logic [DROP_W-1:0]   drop_q, drop_d;
  logic [DROP_W:0]     drop_sum;
  logic [NUM_IN-1:0]   req, stray;
  logic [CNT_W-1:0]    n_stray;
  logic                any_req, locked;

  assign locked      = state_q == LOCKED;
  assign req         = in_valid & in_startofpacket;
  assign stray       = in_valid & ~in_startofpacket & {NUM_IN{~locked}};
  assign busy        = locked;
  assign out_channel = g_q;
  assign drop_count  = drop_q;
  assign drop_sum    = {1'b0, drop_q} + (DROP_W+1)'(n_stray);

  kernel_rr_arbiter #(.NUM_IN(NUM_IN), .CH_W(CH_W)) u_rr (
    .req     (req),
    .rr      (rr_q),
    .gnt_idx (win),
    .any_req (any_req)
  );

  // Number of stray beats discarded this cycle
  always_comb begin
    n_stray = '0;
    for (int i = 0; i < NUM_IN; i++) n_stray = n_stray + CNT_W'(stray[i]);
  end

  // Payload mux from the granted source; zero whenever no packet is locked
  always_comb begin
    out_valid         = locked ? in_valid[g_q] : 1'b0;
    out_data          = locked ? in_data[int'(g_q)*DATA_W +: DATA_W] : '0;
    out_startofpacket = locked ? in_startofpacket[g_q] : 1'b0;
    out_endofpacket   = locked ? in_endofpacket[g_q] : 1'b0;
    out_empty         = locked ? in_empty[int'(g_q)*EMPTY_W +: EMPTY_W] : '0;
  end

  // Next-state: arbitrate and drop strays in IDLE, release the lock on an accepted eop
  always_comb begin
    state_d  = state_q;
    g_d      = g_q;
    rr_d     = rr_q;
    drop_d   = drop_q;
    in_ready = '0;
    if (locked) begin
      in_ready[g_q] = out_ready;
      if (out_valid && out_ready && out_endofpacket) begin
        state_d = IDLE;
        rr_d    = (g_q == CH_W'(NUM_IN - 1)) ? '0 : g_q + CH_W'(1);
      end
    end else begin
      in_ready = stray & {NUM_IN{~reset}};
      drop_d   = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
      state_d  = any_req ? LOCKED : IDLE;
      g_d      = any_req ? win : g_q;
    end
  end

  // State, grant, pointer and drop counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      g_q     <= '0;
      rr_q    <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      rr_q    <= rr_d;
      drop_q  <= drop_d;
    end
  end

endmodule

// File: tb/tb_kernel_st_packet_arbiter.sv
// tb_kernel_st_packet_arbiter: packet-level reference model with beat scoreboard
module tb_kernel_st_packet_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int EW = 2;
  localparam int CW = 2;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic [EW-1:0] empty;
  } beat_t;

  typedef struct packed {
    beat_t         b;
    logic [CW-1:0] ch;
  } exp_t;

  logic            clk = 0, reset = 1;
  logic [N-1:0]    in_valid = '0, in_ready, in_sop = '0, in_eop = '0;
  logic [N*DW-1:0] in_data = '0;
  logic [N*EW-1:0] in_empty = '0;
  logic            out_ready = 0, out_valid, out_sop, out_eop, busy;
  logic [DW-1:0]   out_data;
  logic [EW-1:0]   out_empty;
  logic [CW-1:0]   out_channel;
  logic [15:0]     drop_count;

  beat_t srcq[N][$];
  exp_t  sb[$];
  exp_t  mon_e;
  int    passed = 0, total = 0;
  int    rdy_mode = 0, gap_en = 0;
  int    acc[N];
  logic  m_locked = 0;
  int    m_g = 0, m_rr = 0, m_drop = 0;

  kernel_st_packet_arbiter #(.NUM_IN(N), .DATA_W(DW), .EMPTY_W(EW)) dut (
    .clk               (clk),
    .reset             (reset),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_data           (in_data),
    .in_startofpacket  (in_sop),
    .in_endofpacket    (in_eop),
    .in_empty          (in_empty),
    .out_ready         (out_ready),
    .out_valid         (out_valid),
    .out_data          (out_data),
    .out_startofpacket (out_sop),
    .out_endofpacket   (out_eop),
    .out_empty         (out_empty),
    .out_channel       (out_channel),
    .busy              (busy),
    .drop_count        (drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Every accepted output beat must be the next beat of a packet the model granted
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL sb_extra: got beat %0h expected no beat at %0t", out_data, $time);
      end else begin
        mon_e = sb.pop_front();
        check("sb_beat", {out_data, out_sop, out_eop, out_empty}, mon_e.b);
        check("sb_channel", out_channel, mon_e.ch);
      end
    end
  end

  task automatic add_pkt(input int s, input int len, input int base, input bit mid_sop);
    beat_t b;
    for (int j = 0; j < len; j++) begin
      b.data  = DW'(base + j);
      b.sop   = (j == 0) || (mid_sop && j == 1);
      b.eop   = (j == len - 1);
      b.empty = b.eop ? EW'($urandom_range(0, 3)) : '0;
      srcq[s].push_back(b);
    end
  endtask

  task automatic add_stray(input int s, input int len, input int base);
    beat_t b;
    for (int j = 0; j < len; j++) begin
      b.data  = DW'(base + j);
      b.sop   = 0;
      b.eop   = 0;
      b.empty = '0;
      srcq[s].push_back(b);
    end
  endtask

  task automatic drive();
    beat_t h;
    for (int i = 0; i < N; i++) begin
      if (srcq[i].size() > 0 && (gap_en == 0 || $urandom_range(0, 3) != 0)) begin
        h = srcq[i][0];
        in_valid[i] = 1;
      end else begin
        h = '0;
        in_valid[i] = 0;
      end
      in_data[i*DW +: DW]  = h.data;
      in_sop[i]            = h.sop;
      in_eop[i]            = h.eop;
      in_empty[i*EW +: EW] = h.empty;
    end
    out_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? ~out_ready : 1'($urandom_range(0, 1));
  endtask

  task automatic chk_reset();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_channel", out_channel, 0);
    check("rst_drop", drop_count, 0);
    check("rst_payload", {out_data, out_sop, out_eop, out_empty}, 0);
  endtask

  task automatic step();
    logic [N-1:0] er, req;
    logic         eov;
    int           strays;
    @(negedge clk);
    er = '0; eov = 0; strays = 0; req = '0;
    if (!reset) begin
      if (!m_locked) begin
        for (int i = 0; i < N; i++) begin
          if (in_valid[i] && !in_sop[i]) begin er[i] = 1; strays++; end
          req[i] = in_valid[i] && in_sop[i];
        end
        check("idle_payload", {out_data, out_sop, out_eop, out_empty}, 0);
      end else begin
        eov = in_valid[m_g];
        er[m_g] = out_ready;
        check("lock_payload", {out_data, out_sop, out_eop, out_empty},
              {in_data[m_g*DW +: DW], in_sop[m_g], in_eop[m_g], in_empty[m_g*EW +: EW]});
      end
      check("in_ready", in_ready, er);
      check("out_valid", out_valid, eov);
      check("busy", busy, m_locked);
      check("out_channel", out_channel, m_g);
      check("drop_count", drop_count, m_drop);
      if (!m_locked) begin
        m_drop = (m_drop + strays > 65535) ? 65535 : m_drop + strays;
        if (req != 0) begin
          for (int k = N - 1; k >= 0; k--) if (req[(m_rr + k) % N]) m_g = (m_rr + k) % N;
          m_locked = 1;
          for (int j = 0; j < srcq[m_g].size(); j++) begin
            sb.push_back({srcq[m_g][j], CW'(m_g)});
            if (srcq[m_g][j].eop) break;
          end
        end
      end else if (in_valid[m_g] && out_ready && in_eop[m_g]) begin
        m_locked = 0;
        m_rr = (m_g + 1) % N;
      end
    end
    for (int i = 0; i < N; i++)
      if (in_valid[i] && in_ready[i] && srcq[i].size() > 0) begin
        void'(srcq[i].pop_front());
        acc[i]++;
      end
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic drain(input string name, input int maxc);
    int  c;
    bit  pend;
    c = 0;
    pend = 1;
    while (pend && c < maxc) begin
      pend = m_locked;
      for (int i = 0; i < N; i++) if (srcq[i].size() > 0) pend = 1;
      if (pend) begin step(); c++; end
    end
    total++;
    if (!pend) passed++;
    else $display("FAIL %s_timeout: got %0d cycles expected fewer than %0d", name, c, maxc);
  endtask

  initial begin
    int a0, c;
    for (int i = 0; i < N; i++) acc[i] = 0;
    #1 chk_reset();
    @(posedge clk);
    #1 reset = 0;
    drive();

    // Single 4-beat packet on source 2
    add_pkt(2, 4, 'h10, 0);
    drive();
    drain("pkt4", 50);
    check("src2_beats", acc[2], 4);

    // Three sources contending with 2-beat packets
    for (int r = 0; r < 2; r++) begin
      add_pkt(0, 2, 'h100 + r * 16, 0);
      add_pkt(1, 2, 'h200 + r * 16, 0);
      add_pkt(3, 2, 'h300 + r * 16, 0);
    end
    drive();
    drain("contend", 100);

    // Backpressure toggling during a 3-beat packet carrying an inner sop
    rdy_mode = 1;
    add_pkt(0, 3, 'h400, 1);
    drive();
    drain("toggle", 50);
    rdy_mode = 0;

    // Stray beats and saturation
    add_stray(1, 3, 'h500);
    drive();
    drain("stray", 50);
    check("drop_3", drop_count, 3);
    for (int i = 0; i < N; i++) add_stray(i, 16384, 'h8000);
    drive();
    drain("flood", 20000);
    check("drop_sat", drop_count, 16'hFFFF);

    // Single-beat packets alternating on sources 0 and 1
    for (int k = 0; k < 4; k++) begin
      add_pkt(0, 1, 'h900 + k, 0);
      add_pkt(1, 1, 'hA00 + k, 0);
    end
    drive();
    drain("single", 100);

    // Asynchronous reset in the middle of a packet on source 3
    a0 = acc[3];
    add_pkt(3, 4, 'h600, 0);
    drive();
    c = 0;
    while (acc[3] - a0 < 2 && c < 40) begin step(); c++; end
    check("mid_pkt_reached", c < 40, 1);
    #2 reset = 1;
    #1 chk_reset();
    m_locked = 0; m_g = 0; m_rr = 0; m_drop = 0;
    sb.delete();
    add_pkt(0, 2, 'h700, 0);
    drive();
    @(posedge clk);
    #1 reset = 0;
    drain("after_reset", 50);
    check("drop_after_reset", drop_count, 2);

    // Randomized traffic with valid gaps and random backpressure
    gap_en = 1;
    rdy_mode = 2;
    for (int k = 0; k < 40; k++) begin
      int s;
      s = $urandom_range(0, N - 1);
      if ($urandom_range(0, 4) == 0) add_stray(s, $urandom_range(1, 2), 'hC000 + k * 16);
      add_pkt(s, $urandom_range(1, 5), 'hB000 + k * 16, 1'($urandom_range(0, 1)));
    end
    drive();
    drain("random", 4000);
    check("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
